pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 3-stage core (if_id -> id -> id_ex -> ex). Generates hold (freeze) and flush (bubble) controls for pc_reg, if_id and id_ex, and PC redirect on taken jumps. Handles three conditions: jump/branch redirect from ex, load-use hazards detected against the id-stage source registers, and multi-cycle execute ops (mul/div unit).
Fixed priority: jump > multi-cycle wait > load-use.

Parameters:
FLUSH_CYCLES, 1, cycles flush_if_id_o/flush_id_ex_o stay asserted per jump (1..7)
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before timeout_o sets (2..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
jump_en_i  input  1  ex: taken jump/branch this cycle
jump_addr_i  input  32  ex: jump target
id_rs1_addr_i  input  5  id: rs1 address (same value id drives to regs)
id_rs2_addr_i  input  5  id: rs2 address
id_rs1_used_i  input  1  id: rs1 is a real operand
id_rs2_used_i  input  1  id: rs2 is a real operand
idex_load_i  input  1  instruction in id_ex is a load
idex_rd_addr_i  input  5  id_ex destination register
mdu_start_i  input  1  ex: multi-cycle op issued this cycle
mdu_busy_i  input  1  mul/div unit busy
hold_pc_o  output  1  freeze PC
hold_if_id_o  output  1  freeze if_id
hold_id_ex_o  output  1  freeze id_ex
flush_if_id_o  output  1  load NOP into if_id
flush_id_ex_o  output  1  load NOP into id_ex (reg_wen=0)
pc_redirect_o  output  1  PC loads pc_target_o next edge
pc_target_o  output  32  redirect target
timeout_o  output  1  sticky MDU timeout flag
stall_cnt_o  output  16  saturating count of hold_pc_o cycles
state_o  output  2  current FSM state (debug)

Behaviour:
- Reset (async, rst=1): state RUN, counters 0, timeout_o=0, stall_cnt_o=0, pc_target_o=0. All hold/flush/redirect outputs 0 while rst=1.
- States: RUN=0, LOAD_STALL=1, MDU_WAIT=2, FLUSH=3. Control outputs are combinational (Mealy) from state + inputs; state, counters, target are registered.
- hazard = idex_load_i & idex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)). x0 never hazards.
- RUN:
  - jump_en_i -> same cycle pc_redirect_o=1, pc_target_o=jump_addr_i (combinational pass-through, also registered), flush_if_id_o=flush_id_ex_o=1. Next state FLUSH if FLUSH_CYCLES>1, else RUN.
  - else mdu_start_i -> same cycle hold_pc/if_id/id_ex=1. Next state MDU_WAIT; timeout counter cleared.
  - else hazard -> same cycle hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 (bubble). Next state LOAD_STALL.
  - else all outputs 0.
- LOAD_STALL: one cycle, no holds. The load has moved to ex, so the stall lasts exactly 1 cycle. A new hazard is re-evaluated as in RUN. jump_en_i follows RUN jump handling.
- MDU_WAIT: hold_pc/if_id/id_ex=1 every cycle while mdu_busy_i=1. jump_en_i is ignored: ex holds the multi-cycle op.
  - mdu_busy_i=0 -> holds drop the same cycle; next state RUN.
  - Timeout counter increments per cycle. On reaching MDU_TIMEOUT, timeout_o sets (sticky until rst) and the FSM forces RUN.
- FLUSH: flush_if_id_o=flush_id_ex_o=1, no hold, pc_redirect_o=0. The counter runs FLUSH_CYCLES-1 cycles, then RUN.
  - jump_en_i in FLUSH: new redirect with new target; counter restarts.
  - Hazard and mdu_start_i are ignored, since flushed slots are NOPs.
- Simultaneous events in RUN: jump+hazard -> jump only, no hold. mdu_start+hazard -> MDU handling; the hazard is re-checked after release.
- stall_cnt_o increments each cycle hold_pc_o=1 and saturates at 0xFFFF.
- rst mid-stall/flush: immediate return to reset values; no pending redirect survives.

Test Plan:
- Reset: assert rst mid-MDU_WAIT with holds=1 -> all outputs 0 and state_o=0 asynchronously (before the next clk edge); timeout_o=0.
- Load-use: idex_load_i=1, idex_rd=5, id_rs1=5, rs1_used=1 -> exactly one cycle hold_pc=hold_if_id=flush_id_ex=1, then all 0; stall_cnt_o=1. Repeat with rd=0 -> no stall.
- Jump: jump_en_i=1, addr=0x0000_0100 -> same cycle pc_redirect=1, pc_target=0x100, both flushes=1. With FLUSH_CYCLES=3, flushes stay high 2 more cycles.
- Jump+hazard same cycle -> redirect and flush only, hold_pc=0; a second jump during FLUSH to 0x200 -> target 0x200, flush count restarts.
- MDU: mdu_start_i then busy for 10 cycles -> holds high 11 cycles, then released; jump_en_i pulsed mid-wait is ignored.
- Timeout: MDU_TIMEOUT=64 with busy stuck high -> timeout_o=1 after 64 wait cycles; FSM returns to RUN; flag stays high until rst.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the core datapath and pipe_ctrl.
//   master : core side; drives hazard/jump/MDU status, receives hold/flush/redirect controls.
//   slave  : controller side; the mirror image of master.
// Signals:
//   jump_en_i, jump_addr_i            taken jump/branch from ex and its target
//   id_rs{1,2}_addr_i, id_rs{1,2}_used_i  id-stage source operands
//   idex_load_i, idex_rd_addr_i       load flag and destination of the id_ex instruction
//   mdu_start_i, mdu_busy_i           multi-cycle execute unit status
//   hold_*_o, flush_*_o               stage freeze / bubble controls
//   pc_redirect_o, pc_target_o        PC redirect request and target
//   timeout_o, stall_cnt_o, state_o   sticky MDU timeout, stall counter, FSM state (debug)
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        idex_load_i;
    logic [4:0]  idex_rd_addr_i;
    logic        mdu_start_i;
    logic        mdu_busy_i;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        pc_redirect_o;
    logic [31:0] pc_target_o;
    logic        timeout_o;
    logic [15:0] stall_cnt_o;
    logic [1:0]  state_o;

    modport master (
        output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i,
               id_rs2_used_i, idex_load_i, idex_rd_addr_i, mdu_start_i, mdu_busy_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               pc_redirect_o, pc_target_o, timeout_o, stall_cnt_o, state_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i,
               id_rs2_used_i, idex_load_i, idex_rd_addr_i, mdu_start_i, mdu_busy_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               pc_redirect_o, pc_target_o, timeout_o, stall_cnt_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 3-stage core (if_id -> id -> id_ex -> ex).
// Produces hold/flush controls for pc_reg, if_id and id_ex plus the PC redirect on taken jumps.
// Priority: jump > multi-cycle (MDU) wait > load-use hazard.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   ctrl  pipe_ctrl_if.slave bundle (see rtl/pipe_ctrl_if.sv)
// Parameters:
//   FLUSH_CYCLES  cycles the flush outputs stay high per jump (1..7)
//   MDU_TIMEOUT   max cycles spent in MDU wait before the sticky timeout flag sets (2..255)
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MDU_TIMEOUT  = 64
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMduWait   = 2'd2,
        StFlush     = 2'd3
    } state_e;

    localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MduLast     = 8'(MDU_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] target_q, target_d;

    logic hazard;
    logic take_jump;
    logic hold_pc, hold_if_id, hold_id_ex;
    logic flush_if_id, flush_id_ex;

    // x0 is hardwired zero, so a load into it never creates a dependency.
    assign hazard = ctrl.idex_load_i && (ctrl.idex_rd_addr_i != 5'd0) &&
                    ((ctrl.id_rs1_used_i && (ctrl.id_rs1_addr_i == ctrl.idex_rd_addr_i)) ||
                     (ctrl.id_rs2_used_i && (ctrl.id_rs2_addr_i == ctrl.idex_rd_addr_i)));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        to_cnt_d    = to_cnt_q;
        timeout_d   = timeout_q;
        take_jump   = 1'b0;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        // Mealy outputs are forced quiet while reset is held.
        if (!rst) begin
            unique case (state_q)
                // LOAD_STALL only lasts one cycle; it re-evaluates exactly like RUN.
                StRun, StLoadStall: begin
                    state_d = StRun;
                    if (ctrl.jump_en_i) begin
                        take_jump   = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        flush_cnt_d = FlushReload;
                        if (FLUSH_CYCLES > 1) state_d = StFlush;
                    end else if (ctrl.mdu_start_i) begin
                        hold_pc    = 1'b1;
                        hold_if_id = 1'b1;
                        hold_id_ex = 1'b1;
                        to_cnt_d   = 8'd0;
                        state_d    = StMduWait;
                    end else if (hazard) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                        state_d     = StLoadStall;
                    end
                end
                // ex owns the multi-cycle op, so jumps are not looked at here.
                StMduWait: begin
                    if (ctrl.mdu_busy_i) begin
                        hold_pc    = 1'b1;
                        hold_if_id = 1'b1;
                        hold_id_ex = 1'b1;
                        if (to_cnt_q == MduLast) begin
                            timeout_d = 1'b1;
                            state_d   = StRun;
                        end else begin
                            to_cnt_d = to_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = StRun;
                    end
                end
                // Flushed slots are NOPs: hazards and MDU starts are irrelevant here.
                StFlush: begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (ctrl.jump_en_i) begin
                        take_jump   = 1'b1;
                        flush_cnt_d = FlushReload;
                    end else if (flush_cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign target_d    = take_jump ? ctrl.jump_addr_i : target_q;
    assign stall_cnt_d = (hold_pc && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= 3'd0;
            to_cnt_q    <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            target_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            target_q    <= target_d;
        end
    end

    assign ctrl.hold_pc_o     = hold_pc;
    assign ctrl.hold_if_id_o  = hold_if_id;
    assign ctrl.hold_id_ex_o  = hold_id_ex;
    assign ctrl.flush_if_id_o = flush_if_id;
    assign ctrl.flush_id_ex_o = flush_id_ex;
    assign ctrl.pc_redirect_o = take_jump;
    // The new target is visible in the jump cycle itself, then held from the register.
    assign ctrl.pc_target_o   = target_d;
    assign ctrl.timeout_o     = timeout_q;
    assign ctrl.stall_cnt_o   = stall_cnt_q;
    assign ctrl.state_o       = state_q;

endmodule
